// File: rtl/mips_multicycle_core.sv
// Multi-cycle core: PC, register file, ALU and branch/halt control sequenced by one
// FETCH/DECODE/EXEC/WB FSM, fetching over a req/ack instruction-memory handshake.
module mips_multicycle_core #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                REG_N    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              zero,
    output logic              retired,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state, state_n;

    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] opa, opb, result, alu;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [ADDR_W-1:0] next_pc, npc;
    logic [5:0]        op, rd, rs, rt;
    logic [7:0]        imm8;
    logic              alu_op, wr_en;

    assign op   = ir[5:0];
    assign rd   = ir[11:6];
    assign rs   = ir[17:12];
    assign rt   = ir[23:18];
    assign imm8 = ir[31:24];

    assign alu_op = (op < 6'd7);
    assign wr_en  = (state == S_WB) && alu_op && (rd != 6'd0);

    // Register 0 and indices beyond REG_N fall through to the zero default.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int unsigned i = 1; i < REG_N; i++) begin
            if (rs == 6'(i)) rs_val = regs[i];
            if (rt == 6'(i)) rt_val = regs[i];
        end
    end

    always_comb begin
        alu = '0;
        npc = pc + ADDR_W'(1);
        case (op)
            6'd0: alu = opa + opb;
            6'd1: alu = opa - opb;
            6'd2: alu = opa & opb;
            6'd3: alu = opa | opb;
            6'd4: alu = opa ^ opb;
            6'd5: alu = ($signed(opa) < $signed(opb)) ? DATA_W'(1) : '0;
            6'd6: alu = opa + DATA_W'($signed(imm8));
            6'd7: if (opa == opb) npc = pc + ADDR_W'(1) + ADDR_W'($signed(imm8));
            6'd8: npc = ADDR_W'({rt, rs, rd});
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (imem_ack) state_n = S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = S_WB;
            S_WB:     state_n = (op == 6'd63) ? S_HALT : S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            next_pc <= RESET_PC;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH:  if (imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    opa <= rs_val;
                    opb <= rt_val;
                end
                S_EXEC: begin
                    result  <= alu;
                    next_pc <= npc;
                    if (alu_op) zero <= (alu == '0);
                end
                S_WB: begin
                    pc <= next_pc;
                    for (int unsigned i = 1; i < REG_N; i++)
                        if (wr_en && (rd == 6'(i))) regs[i] <= result;
                end
                default: ;
            endcase
        end
    end

    // Request is gated by rst so an in-flight fetch drops the moment reset asserts.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign retired   = (state == S_WB);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: bench-side instruction memory with
// programmable wait states, hand-computed register/pc/flag expectations.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [15:0] pc;
    logic        zero, retired, halted;

    mips_multicycle_core #(
        .DATA_W(16),
        .ADDR_W(16),
        .REG_N(64),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .zero(zero),
        .retired(retired),
        .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_003E;

    logic [31:0] mem [256];
    int          waits = 0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n_ret = 0;
    int          dbl = 0;
    int          addr_bad = 0;
    int          ret_cyc [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] rd,
                                        input logic [5:0] rs, input logic [5:0] rt,
                                        input logic [7:0] imm);
        return {imm, rt, rs, rd, op};
    endfunction

    // Instruction memory responder: ack after `waits` request cycles, checks address stability.
    initial begin
        int          wcnt;
        logic [15:0] held;
        wcnt = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst || !imem_req) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else begin
                if (wcnt == 0) held = imem_addr;
                else if (imem_addr !== held || imem_addr !== pc) addr_bad++;
                if (wcnt >= waits) begin
                    imem_ack   = 1'b1;
                    imem_rdata = (imem_addr[15:8] == 8'h00) ? mem[imem_addr[7:0]] : NOP;
                    wcnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Retire monitor: timestamps pulses and flags back-to-back ones.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (retired === 1'b1) begin
                n_ret++;
                ret_cyc.push_back(cyc);
                if (prev) dbl++;
            end
            prev = retired;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = NOP;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        n_ret = 0;
        dbl = 0;
        addr_bad = 0;
        ret_cyc.delete();
        #2 rst = 1'b0;
    endtask

    // Returns #1 after the edge that ends the n-th WB, so pc/regs reflect that instruction.
    task automatic wait_retire(input int n, input int budget);
        int i;
        i = 0;
        while (n_ret < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (n_ret < n) check("retire_timeout", 32'(n_ret), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic check_gaps(input string tag, input int gap);
        for (int i = 1; i < ret_cyc.size(); i++)
            check(tag, 32'(ret_cyc[i] - ret_cyc[i-1]), 32'(gap));
    endtask

    initial begin
        int req_hi, pc_bad;

        // Reset state and reset during a stalled fetch
        clear_mem();
        waits = 1000;
        do_reset();
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_req", 32'(imem_req), 32'h1);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midfetch_req_drop", 32'(imem_req), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rel_pc", 32'(pc), 32'h0);
        check("rel_req", 32'(imem_req), 32'h1);
        check("rel_halted", 32'(halted), 32'h0);

        // ALU chain, r0 write, SLT, halt at pc=6
        clear_mem();
        mem[0] = enc(6'd6, 6'd1, 6'd0, 6'd0, 8'd5);
        mem[1] = enc(6'd6, 6'd2, 6'd0, 6'd0, 8'hFD);
        mem[2] = enc(6'd0, 6'd3, 6'd1, 6'd2, 8'd0);
        mem[3] = enc(6'd1, 6'd4, 6'd2, 6'd2, 8'd0);
        mem[4] = enc(6'd6, 6'd0, 6'd0, 6'd0, 8'd7);
        mem[5] = enc(6'd5, 6'd5, 6'd2, 6'd1, 8'd0);
        mem[6] = enc(6'd63, 6'd0, 6'd0, 6'd0, 8'd0);
        waits = 0;
        do_reset();
        wait_retire(4, 100);
        check("chain_pc", 32'(pc), 32'h4);
        check("chain_zero", 32'(zero), 32'h1);
        check("chain_r1", 32'(dut.regs[1]), 32'h0005);
        check("chain_r2", 32'(dut.regs[2]), 32'hFFFD);
        check("chain_r3", 32'(dut.regs[3]), 32'h0002);
        check("chain_r4", 32'(dut.regs[4]), 32'h0000);
        check_gaps("chain_gap", 4);
        wait_retire(6, 100);
        check("r0_stays_0", 32'(dut.regs[0]), 32'h0);
        check("slt_r5", 32'(dut.regs[5]), 32'h1);
        wait_retire(7, 100);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc7", 32'(pc), 32'h7);
        req_hi = 0;
        pc_bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (imem_req) req_hi++;
            if (pc !== 16'h0007) pc_bad++;
        end
        check("halt_req_low", 32'(req_hi), 32'h0);
        check("halt_pc_hold", 32'(pc_bad), 32'h0);
        check("halt_ret_count", 32'(n_ret), 32'h7);
        check("halt_still", 32'(halted), 32'h1);
        check("no_double_retire", 32'(dbl), 32'h0);
        rst = 1'b1;
        #1 check("rst_clears_halt", 32'(halted), 32'h0);

        // Three wait states per fetch
        clear_mem();
        mem[0] = enc(6'd6, 6'd1, 6'd0, 6'd0, 8'd1);
        mem[1] = enc(6'd6, 6'd1, 6'd1, 6'd0, 8'd1);
        mem[2] = enc(6'd6, 6'd1, 6'd1, 6'd0, 8'd1);
        mem[3] = enc(6'd63, 6'd0, 6'd0, 6'd0, 8'd0);
        waits = 3;
        do_reset();
        wait_retire(4, 200);
        check_gaps("wait_gap", 7);
        check("wait_addr_stable", 32'(addr_bad), 32'h0);
        check("wait_r1", 32'(dut.regs[1]), 32'h0003);
        check("wait_halted", 32'(halted), 32'h1);

        // Logic ops, BEQ not-taken/taken, JMP, zero unaffected by branches
        clear_mem();
        mem[0]  = enc(6'd6, 6'd1, 6'd0, 6'd0, 8'd5);
        mem[1]  = enc(6'd6, 6'd2, 6'd0, 6'd0, 8'hFD);
        mem[2]  = enc(6'd2, 6'd6, 6'd1, 6'd2, 8'd0);
        mem[3]  = enc(6'd3, 6'd7, 6'd1, 6'd2, 8'd0);
        mem[4]  = enc(6'd4, 6'd8, 6'd1, 6'd2, 8'd0);
        mem[5]  = enc(6'd6, 6'd9, 6'd0, 6'd0, 8'd0);
        mem[6]  = enc(6'd7, 6'd0, 6'd1, 6'd0, 8'd5);
        mem[7]  = enc(6'd8, 6'd10, 6'd0, 6'd0, 8'd0);
        mem[10] = enc(6'd7, 6'd0, 6'd0, 6'd0, 8'hFF);
        waits = 0;
        do_reset();
        wait_retire(5, 100);
        check("and_r6", 32'(dut.regs[6]), 32'h0005);
        check("or_r7", 32'(dut.regs[7]), 32'hFFFD);
        check("xor_r8", 32'(dut.regs[8]), 32'hFFF8);
        check("xor_zero", 32'(zero), 32'h0);
        wait_retire(7, 100);
        check("beq_nt_pc", 32'(pc), 32'h7);
        check("beq_nt_zero", 32'(zero), 32'h1);
        wait_retire(8, 100);
        check("jmp_pc", 32'(pc), 32'hA);
        wait_retire(11, 100);
        check("beq_loop_pc", 32'(pc), 32'hA);
        check("beq_loop_zero", 32'(zero), 32'h1);

        // JMP to 0xFFFF (target truncated from 18 bits), then NOP wraps pc to 0
        clear_mem();
        mem[0] = enc(6'd8, 6'd63, 6'd63, 6'd63, 8'd0);
        do_reset();
        wait_retire(1, 100);
        check("jmp_top_pc", 32'(pc), 32'hFFFF);
        wait_retire(2, 100);
        check("wrap_pc", 32'(pc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath. Integrates PC, register file, ALU and branch/halt control behind one FSM.
- Fetches instructions from an external instruction memory over a req/ack handshake, which tolerates wait states.
- Executes one instruction per FETCH/DECODE/EXEC/WB pass.
- Exposes PC, zero flag, retire pulse and halt status for the top level and the bench.

Parameters:
- DATA_W, 16, register/ALU datapath width (>=8).
- ADDR_W, 16, instruction address and PC width.
- REG_N, 64, number of architectural registers (2..64); field indices >= REG_N read as 0 and ignore writes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; held high until acknowledged.
- imem_addr  output  ADDR_W  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  instruction valid this cycle.
- imem_rdata  input  32  instruction word.
- pc  output  ADDR_W  current program counter.
- zero  output  1  registered ALU zero flag.
- retired  output  1  one-cycle pulse per completed instruction.
- halted  output  1  core stopped by HALT.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0 during reset, zero=0, retired=0, halted=0, all registers=0. Reset mid-fetch drops imem_req immediately; any late ack is ignored.
- Instruction fields:
  - [5:0] op, [11:6] rd, [17:12] rs, [23:18] rt.
  - [31:24] imm8, sign-extended to DATA_W (ALU) or ADDR_W (branch).
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On a rising edge with imem_ack=1, latch imem_rdata and go to DECODE. Otherwise stay; there is no timeout.
  - DECODE: read rs and rt from the register file into operand registers.
  - EXEC: compute result and next_pc. Update zero for ALU ops 0-6 only.
  - WB:
    - Write rd if the op writes a register and rd != 0.
    - pc <= next_pc.
    - retired=1 for this cycle.
    - Next state is FETCH, or HALT for op 63.
  - HALT: halted=1, imem_req=0, no state change until rst.
- Latency: 4 cycles per instruction when ack arrives in the first FETCH cycle, plus one cycle per wait state.
- Ops:
  - 0 ADD: rd = rs + rt.
  - 1 SUB: rd = rs - rt.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SLT: rd = (signed rs < signed rt) ? 1 : 0.
  - 6 ADDI: rd = rs + sext(imm8).
  - 7 BEQ: if rs == rt, next_pc = pc + 1 + sext(imm8); no register write, zero unchanged.
  - 8 JMP: next_pc = {rt,rs,rd} zero-extended/truncated to ADDR_W.
  - 63 HALT: retires, then enters HALT.
  - All other ops: NOP (pc+1, no write).
- Arithmetic: all results modulo 2^DATA_W, with no overflow flag. PC arithmetic wraps modulo 2^ADDR_W, so pc = 2^ADDR_W-1 goes to 0.
- Register 0 always reads 0; writes to it are discarded.
- Operands are sampled in DECODE. A write in WB is visible to the next instruction's DECODE; no bypass is needed.
- imem_rdata is ignored except on a FETCH edge with ack=1. Ack outside FETCH is ignored.
- retired is never high in two consecutive cycles.

Test Plan:
- Reset/fetch:
  - Stimulus: assert rst mid-FETCH with ack held 0.
  - Response: imem_req falls asynchronously; after release pc=RESET_PC, imem_req=1, halted=0.
- ALU chain:
  - Stimulus: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r2, all with zero-wait ack.
  - Response: r3=2, r4=0, zero=1 after the SUB, retired pulses every 4 cycles, pc=4.
- Wait states:
  - Stimulus: ack delayed 3 cycles on each fetch.
  - Response: each instruction takes 7 cycles; imem_addr is stable during the wait.
- Branch and wrap:
  - Stimulus (1): BEQ r0,r0,imm8=-1 at pc=10. Response: pc stays 10 (infinite loop).
  - Stimulus (2): NOP at pc=0xFFFF with ADDR_W=16. Response: next pc=0.
- Register 0 and SLT:
  - Stimulus: ADDI r0,r0,7; SLT r5,r2,r1 with r2=-3, r1=5.
  - Response: r0 reads 0; r5=1.
- Halt:
  - Stimulus: HALT at pc=6.
  - Response: one retired pulse, halted=1, imem_req stays 0 and pc stays 7 for 20 cycles; rst clears halted.
